// File: rtl/conv_pkg.sv
// Shared types and Q-format constants for the convolution accumulate/requantize path.
// The default constants describe the N=18, Q=12, TAPS=9 build.
// Optional feature macro used by users of this package: CONV_ACC_RELU_EN.
package conv_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    QUANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int CONV_N     = 18;
  localparam int CONV_Q     = 12;
  localparam int CONV_TAPS  = 9;
  localparam int CONV_ACC_W = 32;
  localparam int IN_W       = CONV_N + 10;

  // Half an output LSB expressed in accumulator LSBs; added before the shift.
  localparam int RND_OFS = 1 << (CONV_Q - 1);
  localparam int SAT_MAX = (1 << (CONV_N - 1)) - 1;
  localparam int SAT_MIN = -(1 << (CONV_N - 1));

  // Ceiling log2 for elaboration-time sizing.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_acc_quant_if.sv
// Handshake bundle between the MAC, this stage and the downstream consumer.
// slave: the accumulate/quantize stage. master: the environment driving MAC results
// and consuming window results.
interface conv_acc_quant_if #(
  parameter int N = 18
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic signed [N+9:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [N-1:0]   out_data;
  logic                  out_sat;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sat,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sat,
    output out_ready
  );

endinterface

// File: rtl/fxp_requant.sv
// Combinational requantizer: Q(2Q) accumulator -> Q(Q) N-bit word with
// round-half-up and saturation. Shared with the conv output buffer.
// CONV_ACC_RELU_EN: negative results are forced to 0 (never flagged as saturated).
module fxp_requant #(
  parameter int ACC_W = 32,
  parameter int N     = 18,
  parameter int Q     = 12
) (
  input  logic signed [ACC_W-1:0] i_acc,
  output logic signed [N-1:0]     o_data,
  output logic                    o_sat
);

  // One guard bit so adding the rounding offset can never wrap.
  localparam logic signed [ACC_W:0] RND =
    {{(ACC_W + 1 - Q){1'b0}}, 1'b1, {(Q - 1){1'b0}}};
  localparam logic signed [ACC_W:0] LIM_MAX =
    {{(ACC_W + 2 - N){1'b0}}, {(N - 1){1'b1}}};
  localparam logic signed [ACC_W:0] LIM_MIN =
    {{(ACC_W + 2 - N){1'b1}}, {(N - 1){1'b0}}};
  localparam logic signed [N-1:0] OUT_MAX = {1'b0, {(N - 1){1'b1}}};
  localparam logic signed [N-1:0] OUT_MIN = {1'b1, {(N - 1){1'b0}}};

  logic signed [ACC_W:0] w_sum;
  logic signed [ACC_W:0] w_shr;

  assign w_sum = {i_acc[ACC_W-1], i_acc} + RND;
  assign w_shr = w_sum >>> Q;

  // Clip the rounded value into the signed N-bit range and flag clipping.
  always_comb begin
    o_data = w_shr[N-1:0];
    o_sat  = 1'b0;
`ifdef CONV_ACC_RELU_EN
    if (w_shr[ACC_W]) begin
      o_data = '0;
    end else if (w_shr > LIM_MAX) begin
      o_data = OUT_MAX;
      o_sat  = 1'b1;
    end
`else
    if (w_shr > LIM_MAX) begin
      o_data = OUT_MAX;
      o_sat  = 1'b1;
    end else if (w_shr < LIM_MIN) begin
      o_data = OUT_MIN;
      o_sat  = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/conv_acc_quant.sv
// Convolution MAC downstream stage: sums TAPS MAC results per kernel window,
// requantizes the window sum and holds it on a valid/ready output register.
// Optional build macro: CONV_ACC_RELU_EN (clamp negative results to zero).
//
// state | meaning
// ACCUM | accepting MAC results, summing into r_acc
// QUANT | window complete, requantized result captured into output register
// HOLD  | result presented, waiting for out_ready
module conv_acc_quant
  import conv_pkg::*;
#(
  parameter int N     = CONV_N,
  parameter int Q     = CONV_Q,
  parameter int TAPS  = CONV_TAPS,
  parameter int ACC_W = CONV_ACC_W
) (
  input  logic              clk,
  input  logic              sclr_n,
  conv_acc_quant_if.slave   bus
);

  localparam int W_IN = N + 10;
  localparam int TCW  = (TAPS > 1) ? clog2(TAPS) : 1;

  generate
    if (ACC_W < W_IN + clog2(TAPS)) begin : g_acc_w_check
      $error("conv_acc_quant: ACC_W too narrow for TAPS window");
    end
  endgenerate

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [TCW-1:0]          r_tap_cnt;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [N-1:0]     r_out_data;
  logic                    r_out_sat;
  logic                    r_out_valid;

  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_last;
  logic signed [ACC_W-1:0] w_in_sext;
  logic signed [N-1:0]     w_q_data;
  logic                    w_q_sat;

  assign w_in_sext = {{(ACC_W - W_IN){bus.in_data[W_IN-1]}}, bus.in_data};
  assign w_last    = (r_tap_cnt == TCW'(TAPS - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      ACCUM: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_accept = 1'b1;
          if (w_last) begin
            w_state_nxt = QUANT;
          end
        end
      end
      QUANT: begin
        w_state_nxt = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          w_state_nxt = ACCUM;
        end
      end
      default: begin
        w_state_nxt = ACCUM;
      end
    endcase
  end

  // Window accumulation; the first tap loads instead of adding, so no clear cycle is needed.
  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      r_acc     <= '0;
      r_tap_cnt <= '0;
    end else if (w_accept) begin
      r_acc     <= (r_tap_cnt == '0) ? w_in_sext : r_acc + w_in_sext;
      r_tap_cnt <= w_last ? '0 : r_tap_cnt + TCW'(1);
    end
  end

  fxp_requant #(
    .ACC_W (ACC_W),
    .N     (N),
    .Q     (Q)
  ) u_requant (
    .i_acc  (r_acc),
    .o_data (w_q_data),
    .o_sat  (w_q_sat)
  );

  // Output register: loaded in QUANT, released by the out_ready handshake in HOLD.
  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (r_state == QUANT) begin
      r_out_data  <= w_q_data;
      r_out_sat   <= w_q_sat;
      r_out_valid <= 1'b1;
    end else if (r_state == HOLD && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_sat   = r_out_sat;

endmodule
